pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch stage sitting directly upstream of `flow_ctrl` and the decode pipeline register. Holds the architectural fetch PC, issues single-outstanding requests on the instruction bus and buffers the returned word. It applies the `flow_pc` command together with `next_pc`/`next_pc_four` from `flow_ctrl`. It reports `fetch_wait_o` back as `flow_ctrl`'s `bus_wait_i`, so a missing instruction stalls PC and bubbles decode.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset.
- `NOP_INST`, default `32'h0000_0013`: value driven on `inst_o` when no valid instruction is held.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flow_pc_i`  in  `FLOW_WIDTH`  `FLOW_WORK`/`FLOW_STOP`/`FLOW_REFRESH` from `flow_ctrl`.
- `next_pc_i`  in  `CPU_WIDTH`  redirect target.
- `next_pc_four_i`  in  1  1 = sequential advance; 0 with `FLOW_WORK` = redirect.
- `ibus_req_o`  out  1  fetch request.
- `ibus_addr_o`  out  `CPU_WIDTH`  fetch address (= `pc_q`).
- `ibus_gnt_i`  in  1  request accepted this cycle.
- `ibus_rvalid_i`  in  1  read data valid.
- `ibus_rdata_i`  in  `CPU_WIDTH`  instruction word.
- `inst_o`  out  `CPU_WIDTH`  instruction to decode.
- `inst_pc_o`  out  `CPU_WIDTH`  PC of `inst_o`.
- `inst_valid_o`  out  1  `inst_o` valid.
- `fetch_wait_o`  out  1  = `!inst_valid_o`; drives `flow_ctrl.bus_wait_i`.

## Operation
- **Derived terms:**
  - `redirect` = (`flow_pc_i`==`FLOW_WORK`) & !`next_pc_four_i`.
  - `advance` = (`flow_pc_i`==`FLOW_WORK`) & `next_pc_four_i` & `inst_valid_o`.
  - `refresh` = `flow_pc_i`==`FLOW_REFRESH`.
- **States:**
  - S_IDLE: reset only. Goes to S_REQ on the first edge after `rst_n` rises.
  - S_REQ: `ibus_req_o`=1. On `ibus_gnt_i`, go to S_RESP.
  - S_RESP: wait for `ibus_rvalid_i`. On rvalid with `discard_q`=0, capture the word and `pc_q` into the buffer, set valid and go to S_HOLD. On rvalid with `discard_q`=1, drop the word, clear `discard_q` and go to S_REQ.
  - S_HOLD: `inst_valid_o`=1.
    - `advance`: `pc_q`+=4, clear valid, go to S_REQ.
    - `redirect`: `pc_q`=`next_pc_i`, clear valid, go to S_REQ.
    - `refresh`: clear valid, go to S_REQ at the same `pc_q`.
    - `FLOW_STOP`: hold everything.
- **Redirect in other states** (redirect has priority over everything):
  - S_REQ without gnt: `pc_q`=`next_pc_i`. The address may change while ungranted.
  - S_REQ with gnt in the same cycle: `pc_q`=target, `discard_q`=1, go to S_RESP.
  - S_RESP: `pc_q`=target, `discard_q`=1. If rvalid arrives in the same cycle, drop it and go directly to S_REQ.
- **`refresh` in S_REQ/S_RESP:** no effect; the in-flight fetch completes normally.
- **Arithmetic:** `pc_q`+4 wraps modulo 2^`CPU_WIDTH`. `next_pc_i` is taken unmodified, with no alignment check.
- **Bus discipline:** at most one outstanding request. `ibus_req_o` is never asserted in S_RESP or S_HOLD.
- **Unused output value:** `inst_o`=`NOP_INST` whenever `inst_valid_o`=0.

## Timing
- **Reset values:**
  - `ibus_req_o`=0, `ibus_addr_o`=`RESET_PC`.
  - `inst_valid_o`=0, `inst_o`=`NOP_INST`, `inst_pc_o`=`RESET_PC`.
  - `fetch_wait_o`=1, `discard_q`=0, state S_IDLE.
- **Reset mid-operation:** asynchronous. Returns to reset values immediately; any in-flight response after release is ignored until the next grant.
- **Request timing:** `ibus_req_o` rises in the first cycle after reset release.
- **Fetch latency (registered path):** gnt in cycle N, rvalid in N+1, `inst_valid_o` in N+2.
- **Advance to next request:** `advance` in cycle M gives `ibus_req_o` with `pc_q`+4 in cycle M+1.
- **Ungranted request:** `ibus_req_o` is held until gnt.

## Configuration
- **`PC_FETCH_BYPASS_EN`**
  - Defined: in S_RESP, a non-discarded `ibus_rvalid_i` drives `inst_o`=`ibus_rdata_i`, `inst_pc_o`=`pc_q` and `inst_valid_o`=1 combinationally in the same cycle.
    - If `advance` holds that cycle: go directly to S_REQ with `pc_q`+4, no buffering.
    - Otherwise: capture the word and go to S_HOLD.
    - Latency is gnt N to valid N+1.
  - Undefined: registered path only, gnt N to valid N+2.

## Test plan
- **Reset and first fetch:** release `rst_n`; gnt immediate; rvalid next cycle with `32'h00500093` -> `ibus_addr_o`=`RESET_PC`, then `inst_o`=`00500093`, `inst_pc_o`=0, `inst_valid_o`=1 two cycles after gnt.
- **Sequential stream:** WORK with four=1 each cycle, zero-wait bus -> addresses 0,4,8,C; `fetch_wait_o` pulses between instructions.
- **Redirect in S_RESP:** redirect to `0x100` after gnt, before rvalid -> the returned word is dropped, `inst_valid_o` stays 0, next request addr `0x100`.
- **Redirect coincident with rvalid:** same as above; there is no valid cycle for the old word.
- **STOP for 5 cycles in S_HOLD:** `inst_o`/`inst_pc_o` stable and `ibus_req_o`=0 throughout. Then REFRESH -> valid drops, refetch of the same PC.
- **Wrap and reset:** `pc_q`=`0xFFFFFFFC` with advance -> next addr 0. Assert `rst_n` low mid-S_RESP -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/pc_fetch.sv
// Program-counter and instruction-fetch stage.
// Holds the fetch PC and issues one outstanding instruction-bus request at a time.
// It buffers the returned word for decode and stalls flow_ctrl through fetch_wait_o.
// Optional feature macro: PC_FETCH_BYPASS_EN. When it is defined, a live response
// is forwarded to inst_o in the same cycle it arrives, which saves one cycle of latency.
module pc_fetch #(
  parameter int unsigned              CPU_WIDTH    = 32,
  parameter int unsigned              FLOW_WIDTH   = 2,
  parameter logic [FLOW_WIDTH-1:0]    FLOW_STOP    = 'd0,
  parameter logic [FLOW_WIDTH-1:0]    FLOW_WORK    = 'd1,
  parameter logic [FLOW_WIDTH-1:0]    FLOW_REFRESH = 'd2,
  parameter logic [CPU_WIDTH-1:0]     RESET_PC     = '0,
  parameter logic [CPU_WIDTH-1:0]     NOP_INST     = 'h13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOW_WIDTH-1:0] flow_pc_i,
  input  logic [CPU_WIDTH-1:0]  next_pc_i,
  input  logic                  next_pc_four_i,
  output logic                  ibus_req_o,
  output logic [CPU_WIDTH-1:0]  ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [CPU_WIDTH-1:0]  ibus_rdata_i,
  output logic [CPU_WIDTH-1:0]  inst_o,
  output logic [CPU_WIDTH-1:0]  inst_pc_o,
  output logic                  inst_valid_o,
  output logic                  fetch_wait_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] inst_q, inst_d;
  logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                 discard_q, discard_d;

  logic redirect, advance, refresh, bypass_hit;

  // Flow command decode and optional same-cycle forwarding of a live response
  always_comb begin
    redirect = (flow_pc_i == FLOW_WORK) & ~next_pc_four_i;
    refresh  = (flow_pc_i == FLOW_REFRESH);
`ifdef PC_FETCH_BYPASS_EN
    // A redirect drops the word, so it must never appear as valid
    bypass_hit = (state_q == StResp) & ibus_rvalid_i & ~discard_q & ~redirect;
`else
    bypass_hit = 1'b0;
`endif
    inst_valid_o = (state_q == StHold) | bypass_hit;
    advance      = (flow_pc_i == FLOW_WORK) & next_pc_four_i & inst_valid_o;
  end

  // Output drive; a NOP is shown whenever nothing valid is held
  always_comb begin
    ibus_req_o   = (state_q == StReq);
    ibus_addr_o  = pc_q;
    fetch_wait_o = ~inst_valid_o;
    if (bypass_hit) begin
      inst_o    = ibus_rdata_i;
      inst_pc_o = pc_q;
    end else if (state_q == StHold) begin
      inst_o    = inst_q;
      inst_pc_o = inst_pc_q;
    end else begin
      inst_o    = NOP_INST;
      inst_pc_o = inst_pc_q;
    end
  end

  // Next-state: redirect wins over everything, then advance, then refresh
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (redirect) pc_d = next_pc_i;
        if (ibus_gnt_i) begin
          state_d   = StResp;
          // A grant for the old address is still answered; drop that answer
          discard_d = redirect;
        end
      end
      StResp: begin
        if (redirect) begin
          pc_d = next_pc_i;
          if (ibus_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            discard_d = 1'b1;
          end
        end else if (ibus_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
`ifdef PC_FETCH_BYPASS_EN
            if (advance) begin
              pc_d    = pc_q + CPU_WIDTH'(4);
              state_d = StReq;
            end else begin
              inst_d    = ibus_rdata_i;
              inst_pc_d = pc_q;
              state_d   = StHold;
            end
`else
            inst_d    = ibus_rdata_i;
            inst_pc_d = pc_q;
            state_d   = StHold;
`endif
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = next_pc_i;
          state_d = StReq;
        end else if (advance) begin
          pc_d    = pc_q + CPU_WIDTH'(4);
          state_d = StReq;
        end else if (refresh) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch (default build, registered fetch path).
// Expected grant addresses and delivered instructions are queued by the stimulus.
// A negedge monitor pops and compares them as the DUT presents them.
module tb_pc_fetch;

  localparam logic [1:0]  FLOW_STOP    = 2'd0;
  localparam logic [1:0]  FLOW_WORK    = 2'd1;
  localparam logic [1:0]  FLOW_REFRESH = 2'd2;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  logic        clk, rst_n;
  logic [1:0]  flow_pc;
  logic [31:0] next_pc;
  logic        next_pc_four;
  logic        ibus_req, ibus_gnt, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_rdata;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, fetch_wait;

  pc_fetch #(
    .CPU_WIDTH   (32),
    .FLOW_WIDTH  (2),
    .FLOW_STOP   (FLOW_STOP),
    .FLOW_WORK   (FLOW_WORK),
    .FLOW_REFRESH(FLOW_REFRESH),
    .RESET_PC    (32'h0000_0000),
    .NOP_INST    (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flow_pc_i     (flow_pc),
    .next_pc_i     (next_pc),
    .next_pc_four_i(next_pc_four),
    .ibus_req_o    (ibus_req),
    .ibus_addr_o   (ibus_addr),
    .ibus_gnt_i    (ibus_gnt),
    .ibus_rvalid_i (ibus_rvalid),
    .ibus_rdata_i  (ibus_rdata),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_valid_o  (inst_valid),
    .fetch_wait_o  (fetch_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [8] = '{32'h00500093, 32'h00a00113, 32'h00f00193, 32'h01400213,
                           32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213};

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_inst_q [$];
  int n_cmp = 0;
  int n_err = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: grants are checked against queued addresses, new instructions against queued words
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (ibus_req && ibus_gnt) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL grant_addr: unexpected grant at %h, expected none", ibus_addr);
        end else begin
          check("grant_addr", {32'h0, ibus_addr}, {32'h0, exp_addr_q.pop_front()});
        end
      end
      if (inst_valid && !prev_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL inst_out: unexpected valid %h @ %h, expected none", inst, inst_pc);
        end else begin
          check("inst_out", {inst, inst_pc}, exp_inst_q.pop_front());
        end
      end
      prev_valid <= inst_valid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant the pending request now, return the word one cycle later
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_inst_q.push_back({data, addr});
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt    = 1'b0;
    ibus_rvalid = 1'b1;
    ibus_rdata  = data;
    cyc();
    ibus_rvalid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},     {63'h0, ibus_req},   64'h0);
    check({tag, "_addr"},    {32'h0, ibus_addr},  64'h0);
    check({tag, "_valid"},   {63'h0, inst_valid}, 64'h0);
    check({tag, "_inst"},    {32'h0, inst},       {32'h0, NOP});
    check({tag, "_inst_pc"}, {32'h0, inst_pc},    64'h0);
    check({tag, "_wait"},    {63'h0, fetch_wait}, 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flow_pc = FLOW_STOP; next_pc = '0; next_pc_four = 1'b1;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
    #3;
    check_reset_vals("reset");
    #9 rst_n = 1'b1;
    cyc();
    check("first_req", {63'h0, ibus_req}, 64'h1);

    // Reset and first fetch
    fetch(32'h0, mem[0]);

    // Sequential stream: 4, 8, C with a wait pulse between instructions
    flow_pc = FLOW_WORK; next_pc_four = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("wait_pulse", {63'h0, fetch_wait}, 64'h1);
      fetch(32'(i * 4), mem[i]);
    end
    flow_pc = FLOW_STOP;

    // STOP in hold: outputs stable, no request
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stop_inst", {inst, inst_pc}, {mem[3], 32'hC});
      check("stop_req", {63'h0, ibus_req}, 64'h0);
    end

    // REFRESH: valid drops, refetch the same PC
    flow_pc = FLOW_REFRESH;
    cyc();
    flow_pc = FLOW_STOP;
    check("refresh_valid", {63'h0, inst_valid}, 64'h0);
    fetch(32'hC, mem[3]);

    // Redirect in RESP before rvalid
    flow_pc = FLOW_WORK; next_pc_four = 1'b1;
    cyc();
    flow_pc = FLOW_STOP;
    exp_addr_q.push_back(32'h10);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    flow_pc = FLOW_WORK; next_pc_four = 1'b0; next_pc = 32'h100;
    cyc();
    flow_pc = FLOW_STOP; next_pc_four = 1'b1;
    ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
    cyc();
    ibus_rvalid = 1'b0;
    check("redir_resp_valid", {63'h0, inst_valid}, 64'h0);
    check("redir_resp_addr", {32'h0, ibus_addr}, 64'h100);
    fetch(32'h100, mem[4]);

    // Redirect coincident with rvalid
    flow_pc = FLOW_WORK; next_pc_four = 1'b1;
    cyc();
    flow_pc = FLOW_STOP;
    exp_addr_q.push_back(32'h104);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    ibus_rvalid = 1'b1; ibus_rdata = 32'hBAD0_0BAD;
    flow_pc = FLOW_WORK; next_pc_four = 1'b0; next_pc = 32'h200;
    cyc();
    ibus_rvalid = 1'b0; flow_pc = FLOW_STOP; next_pc_four = 1'b1;
    check("redir_coinc_valid", {63'h0, inst_valid}, 64'h0);
    check("redir_coinc_addr", {32'h0, ibus_addr}, 64'h200);
    fetch(32'h200, mem[5]);

    // Wrap: redirect to the last word, then advance to 0
    flow_pc = FLOW_WORK; next_pc_four = 1'b0; next_pc = 32'hFFFF_FFFC;
    cyc();
    flow_pc = FLOW_STOP; next_pc_four = 1'b1;
    fetch(32'hFFFF_FFFC, mem[6]);
    flow_pc = FLOW_WORK;
    cyc();
    flow_pc = FLOW_STOP;
    check("wrap_addr", {32'h0, ibus_addr}, 64'h0);

    // Asynchronous reset mid-RESP with a response left in flight
    exp_addr_q.push_back(32'h0);
    ibus_gnt = 1'b1;
    cyc();
    ibus_gnt = 1'b0;
    ibus_rvalid = 1'b1; ibus_rdata = 32'h1234_5678;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_reset_req", {63'h0, ibus_req}, 64'h1);
    cyc();
    check("stale_rvalid_ignored", {63'h0, inst_valid}, 64'h0);
    ibus_rvalid = 1'b0;
    fetch(32'h0, mem[7]);
    cyc();
    cyc();
    check("addr_queue_drained", 64'(exp_addr_q.size()), 64'h0);
    check("inst_queue_drained", 64'(exp_inst_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
